// File: rtl/mem_net_req_router.sv
// rtl/mem_net_req_router.sv - memory request router with per-destination outstanding-request credits
//
// Routes one client request stream to one of p_num_dst servers using a select
// field taken from the request address. A single registered output stage sits
// between the decode and the servers. Each server has a credit counter so that
// no more than p_max_out requests are unanswered at any time.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_val    in   client request valid
//   req_rdy    out  router can accept the request on req_msg
//   req_msg    in   client request message (address at p_addr_lsb)
//   dst_val    out  per-server valid, only the buffered destination is driven
//   dst_rdy    in   per-server ready
//   dst_msg    out  per-server message, all carry the buffered message
//   resp_done  in   per-server pulse when that server's response is accepted
//   cnt_err    out  sticky credit-underflow flag, cleared only by reset

module mem_net_req_router #(
  parameter int p_num_dst   = 3,
  parameter int p_opaq_bits = 8,
  parameter int p_msg_bits  = 71 + p_opaq_bits,
  parameter int p_addr_lsb  = 34,
  parameter int p_sel_lsb   = 28,
  parameter int p_max_out   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_val,
  output logic                                  req_rdy,
  input  logic [p_msg_bits-1:0]                 req_msg,
  output logic [p_num_dst-1:0]                  dst_val,
  input  logic [p_num_dst-1:0]                  dst_rdy,
  output logic [p_num_dst-1:0][p_msg_bits-1:0]  dst_msg,
  input  logic [p_num_dst-1:0]                  resp_done,
  output logic                                  cnt_err
);

  localparam int SEL_W = $clog2(p_num_dst);
  localparam int CNT_W = $clog2(p_max_out + 1);

  logic                  out_val_q, out_val_d;
  logic [p_msg_bits-1:0] out_msg_q, out_msg_d;
  logic [SEL_W-1:0]      out_dst_q, out_dst_d;
  logic                  cnt_err_q, cnt_err_d;
  logic [CNT_W-1:0]      cnt_q [p_num_dst];
  logic [CNT_W-1:0]      cnt_d [p_num_dst];

  logic [SEL_W-1:0]      sel_raw;
  logic [SEL_W-1:0]      sel_in;
  logic                  credit_ok;
  logic                  out_fire;
  logic                  in_fire;

  // Destination decode; select codes beyond the last server fold onto it.
  always_comb begin
    sel_raw = req_msg[p_addr_lsb + p_sel_lsb +: SEL_W];
    if (32'(sel_raw) >= p_num_dst) begin
      sel_in = SEL_W'(p_num_dst - 1);
    end else begin
      sel_in = sel_raw;
    end
  end

  assign credit_ok = (32'(cnt_q[sel_in]) < p_max_out);
  assign out_fire  = out_val_q & dst_rdy[out_dst_q];
  // The stage may refill in the same cycle it drains, giving full throughput.
  assign req_rdy   = (~out_val_q | out_fire) & credit_ok;
  assign in_fire   = req_val & req_rdy;

  always_comb begin
    for (int i = 0; i < p_num_dst; i++) begin
      dst_val[i] = out_val_q && (out_dst_q == SEL_W'(i));
      dst_msg[i] = out_msg_q;
    end
  end

  assign cnt_err = cnt_err_q;

  // Output stage next state.
  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_dst_d = out_dst_q;
    if (in_fire) begin
      out_val_d = 1'b1;
      out_msg_d = req_msg;
      out_dst_d = sel_in;
    end else if (out_fire) begin
      out_val_d = 1'b0;
    end
  end

  // Credits are charged on acceptance, so the buffered request already owns one.
  // A release with nothing outstanding is an upstream protocol error: hold at
  // zero and latch the error flag.
  always_comb begin
    cnt_err_d = cnt_err_q;
    for (int i = 0; i < p_num_dst; i++) begin
      cnt_d[i] = cnt_q[i];
      if (in_fire && (sel_in == SEL_W'(i))) begin
        if (!resp_done[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (resp_done[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else begin
          cnt_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_dst_q <= '0;
      cnt_err_q <= 1'b0;
      for (int i = 0; i < p_num_dst; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_dst_q <= out_dst_d;
      cnt_err_q <= cnt_err_d;
      for (int i = 0; i < p_num_dst; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_net_req_router.sv
// tb/tb_mem_net_req_router.sv - directed self-checking bench for mem_net_req_router

module tb_mem_net_req_router;

  localparam int ND = 3;
  localparam int MW = 79;

  logic                     clk;
  logic                     rst;
  logic                     req_val;
  logic                     req_rdy;
  logic [MW-1:0]            req_msg;
  logic [ND-1:0]            dst_val;
  logic [ND-1:0]            dst_rdy;
  logic [ND-1:0][MW-1:0]    dst_msg;
  logic [ND-1:0]            resp_done;
  logic                     cnt_err;

  int passed = 0;
  int total  = 0;
  int accepts;
  logic [MW-1:0] m_a;
  logic [MW-1:0] m_b;

  mem_net_req_router dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_msg   (req_msg),
    .dst_val   (dst_val),
    .dst_rdy   (dst_rdy),
    .dst_msg   (dst_msg),
    .resp_done (resp_done),
    .cnt_err   (cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mk(input logic [31:0] addr, input logic [7:0] tag);
    mk = {13'h1ABC, addr, 2'b11, tag, 24'hC35A69};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    req_val   = 1'b0;
    req_msg   = '0;
    dst_rdy   = '1;
    resp_done = '0;
    cyc();
    cyc();
    check("reset_dst_val", dst_val, 0);
    check("reset_cnt_err", cnt_err, 0);
    rst = 1'b1;
    #1;
    check("post_reset_rdy", req_rdy, 1);
    check("post_reset_msg", dst_msg[0], 0);

    // Basic route to destination 1.
    m_a = mk(32'h1000_0000, 8'h11);
    req_val = 1'b1;
    req_msg = m_a;
    #1 check("basic_rdy", req_rdy, 1);
    cyc();
    req_val = 1'b0;
    check("basic_dst_val", dst_val, 3'b010);
    check("basic_msg1", dst_msg[1], m_a);
    check("basic_cnt1", dut.cnt_q[1], 1);
    cyc();
    check("basic_one_cycle", dst_val, 3'b000);

    // Select code 3 folds onto destination 2.
    req_val = 1'b1;
    req_msg = mk(32'h3000_0000, 8'h22);
    cyc();
    req_val = 1'b0;
    check("oor_dst_val", dst_val, 3'b100);
    check("oor_cnt2", dut.cnt_q[2], 1);

    // Back-to-back stream to 0, 1, 2.
    accepts = 0;
    for (int i = 0; i < 3; i++) begin
      req_val = 1'b1;
      req_msg = mk(32'(i) << 28, 8'(8'h30 + i));
      #1;
      if (req_rdy === 1'b1) accepts = accepts + 1;
      cyc();
    end
    req_val = 1'b0;
    check("stream_accepts", accepts, 3);
    check("stream_last_val", dst_val, 3'b100);
    check("stream_last_msg", dst_msg[2], mk(32'h2000_0000, 8'h32));
    // Counts now 1,2,2; drain them back to zero.
    resp_done = 3'b111;
    cyc();
    resp_done = 3'b110;
    cyc();
    resp_done = 3'b000;
    check("drain_cnt0", dut.cnt_q[0], 0);
    check("drain_cnt1", dut.cnt_q[1], 0);
    check("drain_cnt2", dut.cnt_q[2], 0);
    check("drain_no_err", cnt_err, 0);

    // Credit stall: 4 accepted to destination 0, 5th blocked.
    for (int i = 0; i < 5; i++) begin
      req_val = 1'b1;
      req_msg = mk(32'h0000_0000, 8'(8'h40 + i));
      #1 check($sformatf("credit_rdy_%0d", i), req_rdy, (i < 4) ? 1 : 0);
      if (i < 4) cyc();
    end
    check("credit_cnt0_full", dut.cnt_q[0], 4);
    resp_done = 3'b001;
    cyc();
    resp_done = 3'b000;
    #1 check("credit_release_rdy", req_rdy, 1);
    cyc();
    req_val = 1'b0;
    check("credit_5th_val", dst_val, 3'b001);
    check("credit_5th_msg", dst_msg[0], mk(32'h0, 8'h44));
    check("credit_cnt0_after", dut.cnt_q[0], 4);

    // Simultaneous accept and release on destination 0 at count 2.
    resp_done = 3'b001;
    cyc();
    cyc();
    resp_done = 3'b000;
    check("sim_cnt0_pre", dut.cnt_q[0], 2);
    req_val   = 1'b1;
    req_msg   = mk(32'h0, 8'h55);
    resp_done = 3'b001;
    #1 check("sim_rdy", req_rdy, 1);
    cyc();
    req_val   = 1'b0;
    resp_done = 3'b000;
    check("sim_cnt0", dut.cnt_q[0], 2);
    cyc();

    // Backpressure on destination 2.
    dst_rdy = 3'b011;
    m_a = mk(32'h2000_0000, 8'h66);
    m_b = mk(32'h0000_0000, 8'h77);
    req_val = 1'b1;
    req_msg = m_a;
    cyc();
    req_msg = m_b;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_val_%0d", i), dst_val, 3'b100);
      check($sformatf("bp_msg_%0d", i), dst_msg[2], m_a);
      check($sformatf("bp_rdy_%0d", i), req_rdy, 0);
      cyc();
    end
    dst_rdy = 3'b111;
    #1 check("bp_release_rdy", req_rdy, 1);
    cyc();
    req_val = 1'b0;
    check("bp_next_val", dst_val, 3'b001);
    check("bp_next_msg", dst_msg[0], m_b);
    check("bp_cnt2", dut.cnt_q[2], 1);
    cyc();
    check("bp_done_val", dst_val, 3'b000);

    // Credit underflow on destination 1.
    check("err_cnt1_zero", dut.cnt_q[1], 0);
    resp_done = 3'b010;
    cyc();
    resp_done = 3'b000;
    check("err_set", cnt_err, 1);
    check("err_cnt1_hold", dut.cnt_q[1], 0);
    cyc();
    cyc();
    check("err_sticky", cnt_err, 1);

    // Asynchronous reset during an output stall.
    dst_rdy = 3'b110;
    req_val = 1'b1;
    req_msg = mk(32'h0, 8'h88);
    cyc();
    req_val = 1'b0;
    check("rst_stall_val", dst_val, 3'b001);
    #2 rst = 1'b0;
    #1;
    check("rst_async_val", dst_val, 3'b000);
    check("rst_async_err", cnt_err, 0);
    check("rst_async_cnt0", dut.cnt_q[0], 0);
    check("rst_async_cnt2", dut.cnt_q[2], 0);
    check("rst_async_msg", dst_msg[0], 0);
    cyc();
    rst = 1'b1;
    dst_rdy = 3'b111;
    #1 check("rst_release_rdy", req_rdy, 1);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
